// File: rtl/cdc_wr_arbiter.sv
// Write-side arbiter for the async CDC FIFO: packet-granular round-robin over N_REQ
// requesters, beats tagged {id, last, data}, with a stall watchdog on the lock owner.
module cdc_wr_arbiter #(
    parameter int  N_REQ      = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  TIMEOUT    = 256,
    localparam int ID_W       = $clog2(N_REQ),
    localparam int FIFO_W     = ID_W + 1 + DATA_WIDTH
) (
    input  logic                        clka_i,
    input  logic                        wrst_ni,
    input  logic [N_REQ-1:0]            req_valid_i,
    input  logic [N_REQ-1:0]            req_last_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]            req_ready_o,
    output logic [N_REQ-1:0]            grant_o,
    input  logic                        fifo_wrdy_i,
    output logic                        fifo_wea_o,
    output logic [FIFO_W-1:0]           fifo_dina_o,
    output logic                        busy_o,
    output logic                        err_timeout_o,
    output logic [ID_W-1:0]             err_id_o,
    input  logic                        err_clr_i
);
    // Counter is kept at least 1 bit wide so TIMEOUT=0 still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W-1:0]  ID_MAX     = ID_W'(N_REQ - 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              err_d;
    logic [ID_W-1:0]   err_id_d;

    logic [ID_W-1:0]       win, sel;
    logic                  win_vld, gnt_vld, sel_valid, sel_last, xfer, timeout;
    logic [DATA_WIDTH-1:0] sel_data;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_MAX) ? '0 : id + 1'b1;
    endfunction

    // Scan from the farthest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            int s;
            s = int'(rr_ptr_q) + k;
            if (s >= N_REQ) s = s - N_REQ;
            if (req_valid_i[s]) begin
                win     = ID_W'(s);
                win_vld = 1'b1;
            end
        end
    end

    assign sel       = (state_q == LOCK) ? owner_q : win;
    assign gnt_vld   = wrst_ni && ((state_q == LOCK) || win_vld);
    assign sel_valid = req_valid_i[sel];
    assign sel_last  = req_last_i[sel];
    assign sel_data  = req_data_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer      = gnt_vld && sel_valid && fifo_wrdy_i;

    assign grant_o       = gnt_vld ? (N_REQ'(1) << sel) : '0;
    assign req_ready_o   = xfer ? grant_o : '0;
    assign fifo_wea_o    = xfer;
    assign fifo_dina_o   = {sel, sel_last, sel_data};
    assign busy_o        = (state_q == LOCK);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        stall_d  = stall_q;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (sel_last) begin
                        rr_ptr_d = next_id(sel);
                    end else begin
                        state_d = LOCK;
                        owner_d = sel;
                        stall_d = '0;
                    end
                end
            end
            LOCK: begin
                if (xfer) begin
                    stall_d = '0;
                    if (sel_last) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                    end
                end else if (!sel_valid) begin
                    // Only an absent owner counts as stalled; FIFO backpressure holds the count.
                    if (TIMEOUT != 0 && stall_q == STALL_LAST) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                        timeout  = 1'b1;
                    end else if (stall_q != '1) begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        err_d    = timeout ? 1'b1 : (err_clr_i ? 1'b0 : err_timeout_o);
        err_id_d = timeout ? owner_q : err_id_o;
    end

    always_ff @(posedge clka_i or negedge wrst_ni) begin
        if (!wrst_ni) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            stall_q       <= '0;
            err_timeout_o <= 1'b0;
            err_id_o      <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            stall_q       <= stall_d;
            err_timeout_o <= err_d;
            err_id_o      <= err_id_d;
        end
    end
endmodule

// File: tb/tb_cdc_wr_arbiter.sv
// Directed bench for cdc_wr_arbiter (N_REQ=4, DATA_WIDTH=8, TIMEOUT=8): per-cycle vector
// table for arbitration/lock/backpressure, hand sequences for watchdog and reset.
module tb_cdc_wr_arbiter;
    localparam int N = 4, DW = 8, TO = 8, IDW = 2, FW = IDW + 1 + DW;

    logic          clka_i = 1'b0;
    logic          wrst_ni = 1'b0;
    logic [N-1:0]  req_valid_i = '0, req_last_i = '0;
    logic [N*DW-1:0] req_data_i = 32'h3CA52211;
    logic [N-1:0]  req_ready_o, grant_o;
    logic          fifo_wrdy_i = 1'b1;
    logic          fifo_wea_o;
    logic [FW-1:0] fifo_dina_o;
    logic          busy_o, err_timeout_o;
    logic [IDW-1:0] err_id_o;
    logic          err_clr_i = 1'b0;

    int checks = 0, errors = 0;

    cdc_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clka_i(clka_i), .wrst_ni(wrst_ni), .req_valid_i(req_valid_i), .req_last_i(req_last_i),
        .req_data_i(req_data_i), .req_ready_o(req_ready_o), .grant_o(grant_o),
        .fifo_wrdy_i(fifo_wrdy_i), .fifo_wea_o(fifo_wea_o), .fifo_dina_o(fifo_dina_o),
        .busy_o(busy_o), .err_timeout_o(err_timeout_o), .err_id_o(err_id_o), .err_clr_i(err_clr_i)
    );

    always #5 clka_i = ~clka_i;

    typedef struct {
        logic [N-1:0]  valid, last;
        logic          wrdy;
        logic [N-1:0]  grant, ready;
        logic          wea;
        logic [FW-1:0] dina;
        logic          busy;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge clka_i);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l, input logic w);
        req_valid_i = v;
        req_last_i  = l;
        fifo_wrdy_i = w;
        #2;
    endtask

    initial begin
        // data: req0=11 req1=22 req2=A5 req3=3C
        tbl[0]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 11'h5A5, 1'b0}; // single beat, rr->3
        tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 11'h73C, 1'b0};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 11'h111, 1'b0};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1, 11'h322, 1'b0};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1, 11'h5A5, 1'b0};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1, 11'h73C, 1'b0};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1, 11'h111, 1'b0};
        tbl[7]  = '{4'b1011, 4'b1001, 1'b1, 4'b0010, 4'b0010, 1'b1, 11'h222, 1'b0}; // req1 packet
        tbl[8]  = '{4'b1011, 4'b1001, 1'b1, 4'b0010, 4'b0010, 1'b1, 11'h222, 1'b1};
        tbl[9]  = '{4'b1011, 4'b1011, 1'b1, 4'b0010, 4'b0010, 1'b1, 11'h322, 1'b1};
        tbl[10] = '{4'b1001, 4'b1001, 1'b1, 4'b1000, 4'b1000, 1'b1, 11'h73C, 1'b0}; // skips idle req2
        tbl[11] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1, 11'h011, 1'b0}; // backpressure
        tbl[12] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 11'h000, 1'b1};
        tbl[13] = '{4'b0001, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 11'h000, 1'b1};
        tbl[14] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 11'h111, 1'b1};
        tbl[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 11'h000, 1'b0};
        tbl[16] = '{4'b0101, 4'b0101, 1'b0, 4'b0100, 4'b0000, 1'b0, 11'h000, 1'b0}; // rr=1, stalled
        tbl[17] = '{4'b0101, 4'b0101, 1'b1, 4'b0100, 4'b0100, 1'b1, 11'h5A5, 1'b0};
        tbl[18] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 11'h111, 1'b0};

        // reset state, with everyone requesting
        drive(4'b1111, 4'b1111, 1'b1);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_wea", 32'(fifo_wea_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_err", 32'(err_timeout_o), 0);
        adv();
        wrst_ni = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].last, tbl[i].wrdy);
            chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(tbl[i].grant));
            chk($sformatf("v%0d_ready", i), 32'(req_ready_o), 32'(tbl[i].ready));
            chk($sformatf("v%0d_wea", i), 32'(fifo_wea_o), 32'(tbl[i].wea));
            if (tbl[i].wea) chk($sformatf("v%0d_dina", i), 32'(fifo_dina_o), 32'(tbl[i].dina));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
            chk($sformatf("v%0d_err", i), 32'(err_timeout_o), 0);
            adv();
        end

        // watchdog: req3 opens a packet then goes silent (rr=1 here)
        drive(4'b1000, 4'b0000, 1'b1);
        chk("wd_grant", 32'(grant_o), 32'b1000);
        adv();
        for (int k = 1; k <= TO; k++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            adv();
            if (k < TO) begin
                chk($sformatf("wd_busy%0d", k), 32'(busy_o), 1);
                chk($sformatf("wd_err%0d", k), 32'(err_timeout_o), 0);
            end
        end
        chk("wd_busy_end", 32'(busy_o), 0);
        chk("wd_err_set", 32'(err_timeout_o), 1);
        chk("wd_err_id", 32'(err_id_o), 3);
        drive(4'b1111, 4'b1111, 1'b0);
        chk("wd_rr_next", 32'(grant_o), 32'b0001);
        err_clr_i = 1'b1;
        adv();
        err_clr_i = 1'b0;
        chk("clr_err", 32'(err_timeout_o), 0);
        chk("clr_id_hold", 32'(err_id_o), 3);

        // owner valid but FIFO full for longer than TIMEOUT: no release
        drive(4'b0001, 4'b0000, 1'b1);
        adv();
        for (int k = 0; k < 12; k++) begin
            drive(4'b0001, 4'b0001, 1'b0);
            adv();
        end
        chk("bp_busy", 32'(busy_o), 1);
        chk("bp_err", 32'(err_timeout_o), 0);
        drive(4'b0001, 4'b0001, 1'b1);
        chk("bp_wea", 32'(fifo_wea_o), 1);
        chk("bp_dina", 32'(fifo_dina_o), 32'h111);
        adv();
        chk("bp_done", 32'(busy_o), 0);

        // timeout coincident with err_clr: set wins (rr=1 -> req1)
        err_clr_i = 1'b1;
        drive(4'b0010, 4'b0000, 1'b1);
        chk("co_grant", 32'(grant_o), 32'b0010);
        adv();
        for (int k = 0; k < TO; k++) begin
            drive(4'b0000, 4'b0000, 1'b1);
            adv();
        end
        err_clr_i = 1'b0;
        chk("co_err", 32'(err_timeout_o), 1);
        chk("co_id", 32'(err_id_o), 1);
        chk("co_busy", 32'(busy_o), 0);

        // reset in the middle of a req2 packet (rr=2)
        drive(4'b0100, 4'b0000, 1'b1);
        adv();
        chk("mr_busy_pre", 32'(busy_o), 1);
        wrst_ni = 1'b0;
        drive(4'b1111, 4'b1111, 1'b1);
        chk("mr_grant", 32'(grant_o), 0);
        chk("mr_ready", 32'(req_ready_o), 0);
        chk("mr_wea", 32'(fifo_wea_o), 0);
        chk("mr_busy", 32'(busy_o), 0);
        chk("mr_err", 32'(err_timeout_o), 0);
        chk("mr_err_id", 32'(err_id_o), 0);
        adv();
        wrst_ni = 1'b1;
        drive(4'b1111, 4'b1111, 1'b0);
        chk("mr_rr0", 32'(grant_o), 32'b0001);
        chk("mr_busy_post", 32'(busy_o), 0);
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
